muladd_result_serializer: RTL and testbench
===========================================

# muladd_result_serializer

Downstream consumer of the registered MULADD result word. It buffers 20-bit results in a small FIFO and streams each word out as 4-bit beats over a valid/ready handshake, so the full product fits through the narrow IO pad budget. Upstream is a free-running pipeline that never stalls. A word presented while the FIFO is full is dropped and flagged.

## Interface
Parameters:
- `DATA_W`, default 20: result word width.
- `BEAT_W`, default 4: serial beat width. `DATA_W` must be a multiple of `BEAT_W`.
- `FIFO_DEPTH`, default 4: FIFO depth in words. Must be a power of two.

Ports:
- `clk`, input, 1: the single clock. All logic is rising-edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: result word present this cycle.
- `in_data`, input, `DATA_W`: result word.
- `in_ready`, output, 1: FIFO can accept a word this cycle.
- `ser_valid`, output, 1: beat valid.
- `ser_data`, output, `BEAT_W`: beat payload.
- `ser_last`, output, 1: final beat of the current word.
- `ser_ready`, input, 1: downstream accepts the beat.
- `overflow`, output, 1: sticky flag, set when a word is dropped.
- `fifo_count`, output, clog2(`FIFO_DEPTH`)+1: number of words currently in the FIFO.

## Operation
- **Push:** a word is pushed when `in_valid && in_ready`.
  - `in_ready = !full && !rst`.
  - `in_ready` depends only on the current `fifo_count`. A pop in the same cycle does not allow a push.
- **Drop:** when `in_valid && !in_ready && !rst`, the word is discarded and `overflow` is set to 1. `overflow` stays 1 until reset.
- **FSM states:** IDLE, SHIFT.
  - **IDLE:** if the FIFO is non-empty, pop the head into the shift register, set beat index = 0, and go to SHIFT. `ser_valid` = 0 while in IDLE.
  - **SHIFT:** `ser_valid` = 1. `ser_data` = shift register bits [`BEAT_W`-1:0].
  - Beats go out LSB-first: NB = `DATA_W`/`BEAT_W` beats, 5 by default.
  - On a handshake (`ser_valid && ser_ready`) that is not the last beat: shift right by `BEAT_W` and increment the beat index.
  - On a handshake of the last beat: if the FIFO is non-empty, pop and load the next word and stay in SHIFT. Otherwise go to IDLE.
- **Stability:** while `ser_valid && !ser_ready`, `ser_data` and `ser_last` are held stable.
- **`ser_last`:** 1 only on the final beat of the current word.
- **Simultaneous push and pop:** `fifo_count` is unchanged. The FIFO pointers wrap modulo `FIFO_DEPTH`.
- **Reset:** clears the FIFO, pointers, partial word, beat index and `overflow`, and puts the FSM in IDLE.
  - Reset values: `ser_valid`=0, `ser_data`=0, `ser_last`=0, `overflow`=0, `fifo_count`=0, `in_ready`=0 while `rst` is high.
  - A word in mid-transfer when reset asserts is lost. No further beats of it are emitted.

## Timing
- **Latency:** a word accepted at edge N, with the FIFO empty and the FSM in IDLE:
  - `fifo_count`=1 after edge N.
  - Load at edge N+1.
  - First beat has `ser_valid`=1 after edge N+1.
  - Total: 2 cycles from input handshake to first beat.
- **Throughput:** with `ser_ready` held high, one beat per cycle. Back-to-back words have no idle cycle between them: 5 cycles per word by default.
- **`fifo_count`:** a registered output that reflects pushes and pops from the previous edge.
- **`overflow`:** asserts on the edge that follows the drop cycle.

## Configuration
- Macro: `MULADD_SER_PARITY_EN`.
- **Defined:** each word gets one extra trailing beat, so NB+1 beats per word.
  - The extra beat is `ser_data` = {`BEAT_W`-1 zeros, ^word}, i.e. the XOR of all `DATA_W` bits.
  - `ser_last` is asserted on the parity beat only.
  - The parity is captured when the word is loaded.
- **Undefined:** NB beats per word, with `ser_last` on data beat NB-1. No parity logic is present.

## Test plan
- **Single word:** push 0x12345 with `ser_ready`=1.
  - First `ser_valid` 2 cycles later.
  - Beats are 5,4,3,2,1, with `ser_last` on 1.
  - Then `ser_valid`=0 and `fifo_count`=0.
- **Backpressure:** push 0xABCDE and hold `ser_ready`=0 for 3 cycles on beat 2.
  - `ser_data`=0xC stays stable throughout.
  - Full sequence is E,D,C,B,A.
- **Overflow:** `ser_ready`=0, push 6 consecutive words 1..6.
  - The first word is loaded, so `fifo_count` reaches 4 after word 5.
  - `in_ready`=0 when word 6 is presented.
  - `overflow`=1, and word 6 never appears.
  - Release `ser_ready`: words 1..5 stream out in order with no gaps.
- **Wrap-around:** stream 10 words with `ser_ready`=1 and in_valid every 5th cycle.
  - Output matches input order.
  - `overflow` stays 0.
  - `fifo_count` never exceeds 1.
- **Reset mid-word:** assert `rst` for 1 cycle after beat 2 of 0x12345.
  - `ser_valid`=0 on the next cycle, with `fifo_count`=0 and `overflow`=0.
  - A following push of 0x00001 emits 1,0,0,0,0.
- **Parity** (`MULADD_SER_PARITY_EN` defined): push 0x00007.
  - Beats 7,0,0,0,0,1, with `ser_last` only on the 6th beat.
  - Pushing 0x00003 gives a final parity beat of 0.

Source files
------------

// File: rtl/muladd_result_serializer.sv
// Buffers MULADD result words in a small FIFO and streams each one out LSB-first as narrow beats.
// Optional trailing parity beat per word when MULADD_SER_PARITY_EN is defined.
module muladd_result_serializer #(
   parameter int unsigned DATA_W     = 20,
   parameter int unsigned BEAT_W     = 4,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic [DATA_W-1:0]             in_data,
   output logic                          in_ready,
   output logic                          ser_valid,
   output logic [BEAT_W-1:0]             ser_data,
   output logic                          ser_last,
   input  logic                          ser_ready,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned NB = DATA_W / BEAT_W;
`ifdef MULADD_SER_PARITY_EN
   localparam int unsigned LAST_IDX = NB;
`else
   localparam int unsigned LAST_IDX = NB - 1;
`endif
   localparam int unsigned IDX_W = (LAST_IDX < 2) ? 1 : $clog2(LAST_IDX + 1);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] shreg;
   logic [IDX_W-1:0]  beat_idx;
   logic              overflow_q;
   logic              push, pop, advance;
   logic              empty, full, beat_hs, beat_last;
`ifdef MULADD_SER_PARITY_EN
   logic              parity;
`endif

   assign empty      = (count == '0);
   assign full       = (count == CNT_W'(FIFO_DEPTH));
   assign in_ready   = !full && !rst;
   assign push       = in_valid && in_ready;
   assign ser_valid  = (state_q == SHIFT);
   assign beat_last  = (beat_idx == IDX_W'(LAST_IDX));
   assign beat_hs    = ser_valid && ser_ready;
   assign ser_last   = ser_valid && beat_last;
   assign overflow   = overflow_q;
   assign fifo_count = count;

`ifdef MULADD_SER_PARITY_EN
   assign ser_data = (beat_idx == IDX_W'(NB)) ? BEAT_W'(parity) : shreg[BEAT_W-1:0];
`else
   assign ser_data = shreg[BEAT_W-1:0];
`endif

   // Next state: a last-beat handshake chains straight into the next word when one is waiting.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      advance = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (beat_hs) begin
               if (!beat_last) begin
                  advance = 1'b1;
               end else if (!empty) begin
                  pop = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FIFO storage carries no reset; occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         shreg      <= '0;
         beat_idx   <= '0;
         overflow_q <= 1'b0;
`ifdef MULADD_SER_PARITY_EN
         parity     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (pop) begin
            shreg    <= mem[rd_ptr];
            beat_idx <= '0;
`ifdef MULADD_SER_PARITY_EN
            parity   <= ^mem[rd_ptr];
`endif
         end else if (advance) begin
            shreg    <= shreg >> BEAT_W;
            beat_idx <= beat_idx + IDX_W'(1);
         end
         if (in_valid && !in_ready) begin
            overflow_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_muladd_result_serializer.sv
// Directed bench for muladd_result_serializer; expected beats are queued at push time and popped on each handshake.
module tb_muladd_result_serializer;

   localparam int unsigned DATA_W     = 20;
   localparam int unsigned BEAT_W     = 4;
   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned NB         = DATA_W / BEAT_W;
   localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;
`ifdef MULADD_SER_PARITY_EN
   localparam int unsigned BEATS = NB + 1;
`else
   localparam int unsigned BEATS = NB;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              ser_valid;
   logic [BEAT_W-1:0] ser_data;
   logic              ser_last;
   logic              ser_ready;
   logic              overflow;
   logic [CNT_W-1:0]  fifo_count;

   int tests = 0;
   int fails = 0;
   int hs_cnt = 0;
   logic [BEAT_W:0] exp_q[$];

   muladd_result_serializer #(
      .DATA_W(DATA_W), .BEAT_W(BEAT_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .ser_valid(ser_valid), .ser_data(ser_data), .ser_last(ser_last), .ser_ready(ser_ready),
      .overflow(overflow), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic queue_word(input logic [DATA_W-1:0] d);
      for (int i = 0; i < int'(NB); i++) begin
`ifdef MULADD_SER_PARITY_EN
         exp_q.push_back({1'b0, d[i*BEAT_W +: BEAT_W]});
`else
         exp_q.push_back({(i == int'(NB) - 1), d[i*BEAT_W +: BEAT_W]});
`endif
      end
`ifdef MULADD_SER_PARITY_EN
      exp_q.push_back({1'b1, BEAT_W'(^d)});
`endif
   endtask

   // Scores any beat handshake happening this cycle, then advances one clock.
   task automatic step();
      logic [BEAT_W:0] e;
      if (ser_valid && ser_ready && !rst) begin
         hs_cnt++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL unexpected_beat observed=%0h expected=none", ser_data);
         end else begin
            e = exp_q.pop_front();
            check("beat_data", 32'(ser_data), 32'(e[BEAT_W-1:0]));
            check("beat_last", 32'(ser_last), 32'(e[BEAT_W]));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [DATA_W-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      queue_word(d);
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         step();
         n++;
      end
      check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int n;
      int hs0;
      int max_cnt;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      ser_ready = 1'b0;
      @(posedge clk);
      #1;
      step();
      check("rst_ser_valid", 32'(ser_valid), 32'd0);
      check("rst_ser_data", 32'(ser_data), 32'd0);
      check("rst_ser_last", 32'(ser_last), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_fifo_count", 32'(fifo_count), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("idle_in_ready", 32'(in_ready), 32'd1);

      // Single word: two-cycle latency, LSB-first beats.
      ser_ready = 1'b1;
      hs0 = hs_cnt;
      push_word(20'h12345);
      check("single_count_after_push", 32'(fifo_count), 32'd1);
      check("single_valid_before_load", 32'(ser_valid), 32'd0);
      step();
      check("single_first_valid", 32'(ser_valid), 32'd1);
      check("single_first_data", 32'(ser_data), 32'h5);
      drain(20);
      check("single_beat_count", 32'(hs_cnt - hs0), 32'(BEATS));
      check("single_idle_valid", 32'(ser_valid), 32'd0);
      check("single_idle_count", 32'(fifo_count), 32'd0);

      // Backpressure held on beat 2.
      push_word(20'hABCDE);
      step();
      step();
      step();
      ser_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("bp_valid", 32'(ser_valid), 32'd1);
         check("bp_data_stable", 32'(ser_data), 32'hC);
         check("bp_last_stable", 32'(ser_last), 32'd0);
         step();
      end
      check("bp_data_after", 32'(ser_data), 32'hC);
      ser_ready = 1'b1;
      drain(20);

      // Overflow: word 1 loads, words 2..5 fill the FIFO, word 6 is dropped.
      ser_ready = 1'b0;
      for (int w = 1; w <= 6; w++) begin
         in_valid = 1'b1;
         in_data  = DATA_W'(w);
         if (w <= 5) begin
            check("ovf_in_ready", 32'(in_ready), 32'd1);
            queue_word(DATA_W'(w));
         end else begin
            check("ovf_count_full", 32'(fifo_count), 32'd4);
            check("ovf_in_ready_full", 32'(in_ready), 32'd0);
         end
         step();
      end
      in_valid = 1'b0;
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_count_hold", 32'(fifo_count), 32'd4);
      ser_ready = 1'b1;
      n = 0;
      while (exp_q.size() > 0 && n < 60) begin
         if (!ser_valid) check("ovf_no_gap", 32'(ser_valid), 32'd1);
         step();
         n++;
      end
      check("ovf_drain_cycles", 32'(n), 32'(5 * BEATS));
      check("ovf_drain_empty", 32'(exp_q.size()), 32'd0);
      check("ovf_sticky", 32'(overflow), 32'd1);
      check("ovf_count_end", 32'(fifo_count), 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("ovf_cleared_by_rst", 32'(overflow), 32'd0);

      // Wrap-around: one word every BEATS cycles keeps occupancy at most 1.
      max_cnt = 0;
      for (int k = 0; k < 10 * int'(BEATS); k++) begin
         if (k % int'(BEATS) == 0) begin
            in_valid = 1'b1;
            in_data  = DATA_W'($urandom);
            queue_word(in_data);
         end else begin
            in_valid = 1'b0;
         end
         step();
         if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      end
      in_valid = 1'b0;
      drain(40);
      check("wrap_max_count_le1", 32'(max_cnt <= 1), 32'd1);
      check("wrap_no_overflow", 32'(overflow), 32'd0);

      // Reset mid-word discards the remaining beats.
      push_word(20'h12345);
      step();
      step();
      step();
      step();
      rst = 1'b1;
      exp_q.delete();
      step();
      rst = 1'b0;
      check("midrst_valid", 32'(ser_valid), 32'd0);
      check("midrst_count", 32'(fifo_count), 32'd0);
      check("midrst_overflow", 32'(overflow), 32'd0);
      step();
      check("midrst_no_beats", 32'(ser_valid), 32'd0);
      hs0 = hs_cnt;
      push_word(20'h00001);
      drain(20);
      check("midrst_next_beats", 32'(hs_cnt - hs0), 32'(BEATS));

`ifdef MULADD_SER_PARITY_EN
      hs0 = hs_cnt;
      push_word(20'h00007);
      push_word(20'h00003);
      drain(30);
      check("parity_beat_count", 32'(hs_cnt - hs0), 32'(2 * BEATS));
`endif

      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
